addsub_issue_stage: RTL and testbench
=====================================

Name: addsub_issue_stage

Overview:
- Issue stage directly upstream of the 64-bit carry-lookahead adder in the EX units.
- Accepts add/subtract-class micro-ops from decode and buffers them in a small FIFO.
- Resolves each op into adder operands (a, effective b, carry_in) and issues them with a valid/ready handshake.
- Owns the architectural carry flag (CF), which the adder result path writes back. Interlocks carry-consuming ops until all older carry writers have retired.

Parameters:
- WIDTH, 64: operand width.
- TAG_W, 5: destination tag width.
- DEPTH, 2: FIFO entries (power of two, ≥2).
- MAX_INFLIGHT, 4: maximum issued ops whose CF writeback is outstanding.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode offers an op.
- in_ready  out  1  stage accepts; equals !fifo_full.
- in_op  in  3  opcode (encoding under Behaviour).
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_tag  in  TAG_W  destination tag.
- issue_valid  out  1  operands valid toward the adder.
- issue_ready  in  1  adder/result path accepts.
- issue_a  out  WIDTH  adder A.
- issue_b  out  WIDTH  adder B (possibly inverted).
- issue_carry_in  out  1  adder carry_in.
- issue_op  out  3  opcode passthrough.
- issue_tag  out  TAG_W  tag passthrough.
- cf_wr_en  in  1  carry writeback strobe from the result path.
- cf_wr_data  in  1  carry_out value being written back.
- cf  out  1  current carry flag.
- illegal_op  out  1  one-cycle pulse when an illegal op is dropped.
- err_underflow  out  1  sticky: cf_wr_en arrived with no writer outstanding.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied; pending counter = 0; cf = 0; illegal_op = 0; err_underflow = 0.
  - in_ready = 1; issue_valid = 0.
  - Reset mid-operation discards all buffered ops. In-flight writebacks arriving after reset count as underflow.
- Opcodes:
  - ADD=0: b = in_b, cin = 0.
  - SUB=1: b = ~in_b, cin = 1.
  - ADC=2: b = in_b, cin = cf.
  - SBC=3: b = ~in_b, cin = cf.
  - CMP=4: as SUB.
  - NEG=5: a = 0, b = ~in_b, cin = 1.
  - Codes 6 and 7 are illegal.
  - All legal ops are CF writers. ADC and SBC are CF readers.
- Enqueue:
  - Push on in_valid && in_ready for legal ops. The FIFO stores op, a, b, tag raw.
  - An illegal op is accepted but not stored; illegal_op pulses high the following cycle.
- Issue:
  - Operands are decoded combinationally from the FIFO head; there is no combinational path from in_* to issue_*.
  - Minimum latency: push in cycle N, issue_valid in cycle N+1.
  - issue_valid = !empty && !(head is CF reader && pending != 0) && (pending != MAX_INFLIGHT).
  - Pop on issue_valid && issue_ready.
  - Outputs stay stable while issue_valid && !issue_ready. For CF readers, cf cannot change because pending = 0.
- Pending counter:
  - +1 on pop; −1 on cf_wr_en.
  - Both in the same cycle: unchanged.
  - cf_wr_en when pending = 0: cf is not updated, counter stays 0, err_underflow sets.
- CF update: on accepted cf_wr_en, cf <= cf_wr_data, visible the next cycle.
- Full FIFO: in_ready = 0, so push and pop cannot coincide while full. Push and pop in the same cycle are allowed otherwise.
- Pointers wrap modulo DEPTH; count is held separately (log2(DEPTH)+1 bits).

Decomposition:
- Package ex_pkg:
  - addsub_op_e enum (ADD..NEG), with function is_cf_reader(op) and function is_legal(op).
  - Default WIDTH and TAG_W localparams.
- Sub-module ex_sync_fifo: parameterised width/depth, push/pop/full/empty/head. Reusable by neighbouring EX stages.
- The issue decode and pending counter stay in the top module.

Test Plan:
- SUB, a=10, b=3, pending=0, issue_ready=1 -> next cycle issue_b=~3 (0xFFFF_FFFF_FFFF_FFFC), carry_in=1, issue_op=1.
- ADC with pending=1 -> issue_valid held 0. Then cf_wr_en=1, cf_wr_data=1 -> cf=1 and pending=0 next cycle, then issue_valid=1 with carry_in=1.
- Hold issue_ready=0 and push 3 ops with DEPTH=2 -> in_ready=0 after 2 pushes, third waits. Then issue_ready=1 -> ops issue in order with tags 1, 2, 3.
- Issue 4 ADDs with no writeback -> pending=4, fifth op held with issue_valid=0 until one cf_wr_en.
- in_op=7 -> accepted, illegal_op=1 for one cycle, nothing issued. cf_wr_en at pending=0 -> err_underflow=1, cf unchanged.
- Assert reset with 2 ops buffered and pending=2 -> issue_valid=0, in_ready=1, cf=0 immediately (asynchronous).

Source files
------------

// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg
// Shared definitions for the EX-unit front end: add/subtract opcode
// encoding, opcode classification helpers and default datapath widths.
// ---------------------------------------------------------------------------
package ex_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_TAG_W = 5;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_ADC = 3'd2,
        OP_SBC = 3'd3,
        OP_CMP = 3'd4,
        OP_NEG = 3'd5
    } addsub_op_e;

    // Codes 6 and 7 have no meaning for the adder.
    function automatic logic is_legal(input logic [2:0] op);
        return (op <= 3'd5);
    endfunction

    // Ops whose carry_in is taken from the architectural carry flag.
    function automatic logic is_cf_reader(input logic [2:0] op);
        return (op == 3'd2) || (op == 3'd3);
    endfunction

endpackage

// File: rtl/ex_sync_fifo.sv
// ---------------------------------------------------------------------------
// ex_sync_fifo
// Small synchronous FIFO with a show-ahead head. Pointers wrap modulo DEPTH
// (power of two); occupancy is tracked in a separate counter.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   push, wdata       write request and data (ignored when full)
//   pop               read request (ignored when empty)
//   full, empty       occupancy status
//   head              oldest entry, valid whenever !empty
// ---------------------------------------------------------------------------
module ex_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign head      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array: written at the tail on an accepted push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/addsub_issue_stage.sv
// ---------------------------------------------------------------------------
// addsub_issue_stage
// Buffers add/subtract micro-ops from decode, resolves them into adder
// operands (a, effective b, carry_in) and issues them with valid/ready.
// Owns the carry flag and interlocks carry readers behind older writers.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   in_valid/in_ready, in_op/a/b/tag   op from decode
//   issue_valid/issue_ready, issue_a/b/carry_in/op/tag   toward the adder
//   cf_wr_en, cf_wr_data            carry writeback from the result path
//   cf                              architectural carry flag
//   illegal_op                      one-cycle pulse when an illegal op is dropped
//   err_underflow                   sticky: writeback with nothing outstanding
// ---------------------------------------------------------------------------
module addsub_issue_stage
    import ex_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int TAG_W        = DEFAULT_TAG_W,
    parameter int DEPTH        = 2,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [WIDTH-1:0] issue_a,
    output logic [WIDTH-1:0] issue_b,
    output logic             issue_carry_in,
    output logic [2:0]       issue_op,
    output logic [TAG_W-1:0] issue_tag,
    input  logic             cf_wr_en,
    input  logic             cf_wr_data,
    output logic             cf,
    output logic             illegal_op,
    output logic             err_underflow
);

    localparam int ENTRY_W = 3 + 2 * WIDTH + TAG_W;
    localparam int PEND_W  = $clog2(MAX_INFLIGHT + 1);

    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic               wr_acc_s;
    logic               issue_valid_s;
    logic [ENTRY_W-1:0] head_s;
    logic [2:0]         head_op_s;
    logic [WIDTH-1:0]   head_a_s;
    logic [WIDTH-1:0]   head_b_s;
    logic [TAG_W-1:0]   head_tag_s;
    logic [WIDTH-1:0]   dec_a_s;
    logic [WIDTH-1:0]   dec_b_s;
    logic               dec_cin_s;
    logic [PEND_W-1:0]  pending_r;
    logic               cf_r;
    logic               illegal_r;
    logic               underflow_r;

    assign in_ready = !full_s;
    assign push_s   = in_valid && !full_s && is_legal(in_op);

    ex_sync_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .wdata ({in_op, in_a, in_b, in_tag}),
        .pop   (pop_s),
        .full  (full_s),
        .empty (empty_s),
        .head  (head_s)
    );

    assign {head_op_s, head_a_s, head_b_s, head_tag_s} = head_s;

    // A carry reader waits until every older writer has written back, so
    // the cf it samples cannot change while it sits at the head.
    assign issue_valid_s = !empty_s
                        && !(is_cf_reader(head_op_s) && (pending_r != {PEND_W{1'b0}}))
                        && (pending_r != PEND_W'(MAX_INFLIGHT));
    assign pop_s    = issue_valid_s && issue_ready;
    assign wr_acc_s = cf_wr_en && (pending_r != {PEND_W{1'b0}});

    // Resolve head op into adder operands; subtraction is a + ~b + carry.
    always_comb begin
        dec_a_s   = head_a_s;
        dec_b_s   = head_b_s;
        dec_cin_s = 1'b0;
        case (addsub_op_e'(head_op_s))
            OP_ADD: begin
                dec_b_s   = head_b_s;
                dec_cin_s = 1'b0;
            end
            OP_SUB, OP_CMP: begin
                dec_b_s   = ~head_b_s;
                dec_cin_s = 1'b1;
            end
            OP_ADC: begin
                dec_b_s   = head_b_s;
                dec_cin_s = cf_r;
            end
            OP_SBC: begin
                dec_b_s   = ~head_b_s;
                dec_cin_s = cf_r;
            end
            OP_NEG: begin
                dec_a_s   = {WIDTH{1'b0}};
                dec_b_s   = ~head_b_s;
                dec_cin_s = 1'b1;
            end
            default: begin
                dec_a_s   = head_a_s;
                dec_b_s   = head_b_s;
                dec_cin_s = 1'b0;
            end
        endcase
    end

    assign issue_valid    = issue_valid_s;
    assign issue_a        = dec_a_s;
    assign issue_b        = dec_b_s;
    assign issue_carry_in = dec_cin_s;
    assign issue_op       = head_op_s;
    assign issue_tag      = head_tag_s;

    // Outstanding-writer counter: +1 per issue, -1 per accepted writeback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r <= {PEND_W{1'b0}};
        end else begin
            case ({pop_s, wr_acc_s})
                2'b10:   pending_r <= pending_r + PEND_W'(1);
                2'b01:   pending_r <= pending_r - PEND_W'(1);
                default: pending_r <= pending_r;
            endcase
        end
    end

    // Carry flag and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cf_r        <= 1'b0;
            illegal_r   <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                cf_r <= cf_wr_data;
            end
            illegal_r   <= in_valid && !full_s && !is_legal(in_op);
            underflow_r <= underflow_r || (cf_wr_en && (pending_r == {PEND_W{1'b0}}));
        end
    end

    assign cf            = cf_r;
    assign illegal_op    = illegal_r;
    assign err_underflow = underflow_r;

endmodule

// File: tb/tb_addsub_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_addsub_issue_stage
// Randomized bench for addsub_issue_stage against a queue-based model of the
// stage. Issued operands are judged by the arithmetic result they produce.
// ---------------------------------------------------------------------------
module tb_addsub_issue_stage;

    localparam int WIDTH  = 64;
    localparam int TAG_W  = 5;
    localparam int DEPTH  = 2;
    localparam int MAXINF = 4;
    localparam int CYCLES = 3200;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             issue_valid;
    logic             issue_ready;
    logic [WIDTH-1:0] issue_a;
    logic [WIDTH-1:0] issue_b;
    logic             issue_carry_in;
    logic [2:0]       issue_op;
    logic [TAG_W-1:0] issue_tag;
    logic             cf_wr_en;
    logic             cf_wr_data;
    logic             cf;
    logic             illegal_op;
    logic             err_underflow;

    always #5 clk = ~clk;

    addsub_issue_stage #(
        .WIDTH        (WIDTH),
        .TAG_W        (TAG_W),
        .DEPTH        (DEPTH),
        .MAX_INFLIGHT (MAXINF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_tag         (in_tag),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_a        (issue_a),
        .issue_b        (issue_b),
        .issue_carry_in (issue_carry_in),
        .issue_op       (issue_op),
        .issue_tag      (issue_tag),
        .cf_wr_en       (cf_wr_en),
        .cf_wr_data     (cf_wr_data),
        .cf             (cf),
        .illegal_op     (illegal_op),
        .err_underflow  (err_underflow)
    );

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } op_t;

    // Reference model state
    op_t q[$];
    int  pending;
    bit  m_cf;
    bit  m_ill;
    bit  m_uf;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit reads_cf(input logic [2:0] op);
        return (op == 3'd2) || (op == 3'd3);
    endfunction

    // {carry_out, result} the adder should produce for this op.
    function automatic logic [64:0] expected_sum(input op_t e, input bit c);
        logic [64:0] r;
        bit          brw;
        case (e.op)
            3'd0:       r = {1'b0, e.a} + {1'b0, e.b};
            3'd1, 3'd4: r = {(e.a >= e.b), e.a - e.b};
            3'd2:       r = {1'b0, e.a} + {1'b0, e.b} + 65'(c);
            3'd3: begin
                brw = !c;
                r   = {({1'b0, e.a} >= ({1'b0, e.b} + 65'(brw))), e.a - e.b - 64'(brw)};
            end
            3'd5:       r = {(e.b == 64'd0), 64'd0 - e.b};
            default:    r = 65'd0;
        endcase
        return r;
    endfunction

    function automatic bit model_valid();
        return (q.size() > 0) && !(reads_cf(q[0].op) && pending > 0) && (pending < MAXINF);
    endfunction

    task automatic check_outputs();
        bit exp_cin;
        bit v;
        v = model_valid();
        check("in_ready", 65'(in_ready), 65'(q.size() < DEPTH));
        check("issue_valid", 65'(issue_valid), 65'(v));
        check("cf", 65'(cf), 65'(m_cf));
        check("illegal_op", 65'(illegal_op), 65'(m_ill));
        check("err_underflow", 65'(err_underflow), 65'(m_uf));
        if (v) begin
            case (q[0].op)
                3'd0:       exp_cin = 1'b0;
                3'd2, 3'd3: exp_cin = m_cf;
                default:    exp_cin = 1'b1;
            endcase
            check("issue_op", 65'(issue_op), 65'(q[0].op));
            check("issue_tag", 65'(issue_tag), 65'(q[0].tag));
            check("carry_in", 65'(issue_carry_in), 65'(exp_cin));
            check("adder_sum", {1'b0, issue_a} + {1'b0, issue_b} + 65'(issue_carry_in),
                  expected_sum(q[0], m_cf));
        end
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_step();
        bit pop;
        bit acc;
        pop = model_valid() && issue_ready;
        acc = in_valid && (q.size() < DEPTH);
        if (cf_wr_en) begin
            if (pending > 0) begin
                m_cf = cf_wr_data;
                pending--;
            end else begin
                m_uf = 1'b1;
            end
        end
        if (pop) begin
            void'(q.pop_front());
            pending++;
        end
        m_ill = acc && (in_op >= 3'd6);
        if (acc && in_op < 3'd6) begin
            q.push_back('{op: in_op, a: in_a, b: in_b, tag: in_tag});
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        q.delete();
        pending = 0;
        m_cf    = 1'b0;
        m_ill   = 1'b0;
        m_uf    = 1'b0;
        check("rst_issue_valid", 65'(issue_valid), 65'd0);
        check("rst_in_ready", 65'(in_ready), 65'd1);
        check("rst_cf", 65'(cf), 65'd0);
        check("rst_illegal", 65'(illegal_op), 65'd0);
        check("rst_underflow", 65'(err_underflow), 65'd0);
        reset = 1'b1;
    endtask

    int ready_pct[4] = '{80, 10, 60, 95};
    int wr_pct[4]    = '{40, 40, 5, 60};

    initial begin
        int ph;
        int sel;
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_op       = 3'd0;
        in_a        = '0;
        in_b        = '0;
        in_tag      = '0;
        issue_ready = 1'b0;
        cf_wr_en    = 1'b0;
        cf_wr_data  = 1'b0;
        #2;
        apply_reset();

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            ph = (cyc / 400) % 4;
            in_valid = ($urandom_range(0, 99) < 60);
            in_op    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7))
                                                   : 3'($urandom_range(0, 5));
            in_a     = {$urandom, $urandom};
            sel      = $urandom_range(0, 3);
            case (sel)
                0:       in_b = in_a;
                1:       in_b = 64'd0;
                default: in_b = {$urandom, $urandom};
            endcase
            in_tag      = TAG_W'($urandom);
            issue_ready = ($urandom_range(0, 99) < ready_pct[ph]);
            cf_wr_en    = (pending > 0) ? ($urandom_range(0, 99) < wr_pct[ph])
                                        : ($urandom_range(0, 99) < 3);
            cf_wr_data  = 1'($urandom);
            #1;
            check_outputs();
            if (cyc == 1000 || cyc == 2200) begin
                apply_reset();
            end
            @(posedge clk);
            model_step();
        end

        @(negedge clk);
        in_valid = 1'b0;
        cf_wr_en = 1'b0;
        #1;
        check_outputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
